// File: rtl/bp_stream_out_arbiter.sv
// Packet-locked round-robin arbiter that merges several on-chip beat streams
// onto one registered host-bound stream, with forced termination of overlong packets.
module bp_stream_out_arbiter #(
  parameter int num_src_p           = 3,
  parameter int stream_data_width_p = 32,
  parameter int max_beats_p         = 16
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_src_p-1:0]                     src_v_i,
  input  logic [num_src_p*stream_data_width_p-1:0] src_data_i,
  input  logic [num_src_p-1:0]                     src_last_i,
  output logic [num_src_p-1:0]                     src_yumi_o,
  output logic                                     stream_v_o,
  output logic [stream_data_width_p-1:0]           stream_data_o,
  output logic                                     stream_last_o,
  input  logic                                     stream_ready_i,
  output logic [$clog2(num_src_p)-1:0]             grant_id_o,
  output logic                                     busy_o,
  output logic                                     err_o
);

  localparam int id_w  = $clog2(num_src_p);
  localparam int cnt_w = $clog2(max_beats_p + 1);

  localparam logic [0:0] e_idle = 1'b0;
  localparam logic [0:0] e_lock = 1'b1;

  logic [0:0]       state_r;
  logic [id_w-1:0]  rr_ptr_r;
  logic [id_w-1:0]  grant_id_r;
  logic [cnt_w-1:0] beat_cnt_r;
  logic             err_r;

  logic                           load_en;
  logic                           sel_found;
  logic [id_w-1:0]                sel_id;
  logic [id_w-1:0]                cand;
  int                             idx;
  logic                           accept;
  logic [stream_data_width_p-1:0] sel_data;
  logic                           sel_last;
  logic [cnt_w-1:0]               next_cnt;
  logic                           overrun;
  logic                           end_pkt;

  // The output slot can take a new beat whenever it is empty or draining this cycle.
  assign load_en = ~stream_v_o | stream_ready_i;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    idx       = 0;
    if (state_r == e_lock) begin
      sel_found = src_v_i[grant_id_r];
      sel_id    = grant_id_r;
    end else begin
      for (int k = 1; k <= num_src_p; k++) begin
        idx = int'(rr_ptr_r) + k;
        if (idx >= num_src_p) idx = idx - num_src_p;
        cand = id_w'(idx);
        if (!sel_found && src_v_i[cand]) begin
          sel_found = 1'b1;
          sel_id    = cand;
        end
      end
    end
  end

  assign accept   = sel_found & load_en & reset_i;
  assign sel_data = src_data_i[sel_id*stream_data_width_p +: stream_data_width_p];
  assign sel_last = src_last_i[sel_id];
  assign next_cnt = (state_r == e_lock) ? beat_cnt_r + cnt_w'(1) : cnt_w'(1);

  // A locked packet reaching the beat limit without its own last flag is cut here.
  assign overrun  = (state_r == e_lock) && (next_cnt == cnt_w'(max_beats_p)) && !sel_last;
  assign end_pkt  = sel_last | overrun | (max_beats_p == 1);

  assign src_yumi_o = accept ? ({{(num_src_p-1){1'b0}}, 1'b1} << sel_id) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stream_v_o    <= 1'b0;
      stream_data_o <= '0;
      stream_last_o <= 1'b0;
      state_r       <= e_idle;
      beat_cnt_r    <= '0;
      err_r         <= 1'b0;
      rr_ptr_r      <= id_w'(num_src_p - 1);
      grant_id_r    <= id_w'(num_src_p - 1);
    end else begin
      if (load_en) begin
        stream_v_o <= accept;
        if (accept) begin
          stream_data_o <= sel_data;
          stream_last_o <= end_pkt;
        end
      end
      if (accept) begin
        grant_id_r <= sel_id;
        beat_cnt_r <= next_cnt;
        if (end_pkt) begin
          state_r  <= e_idle;
          rr_ptr_r <= sel_id;
        end else begin
          state_r  <= e_lock;
        end
        if (overrun) err_r <= 1'b1;
      end
    end
  end

  assign grant_id_o = grant_id_r;
  assign busy_o     = (state_r == e_lock);
  assign err_o      = err_r;

endmodule

// File: tb/tb_bp_stream_out_arbiter.sv
// Scoreboard bench for bp_stream_out_arbiter: per-source beat queues feed the DUT,
// each test pushes the beats it expects on the host stream, and every handshake pops one.
module tb_bp_stream_out_arbiter;

  localparam int N    = 3;
  localparam int W    = 32;
  localparam int MB   = 4;
  localparam int ID_W = $clog2(N);

  logic             clk = 1'b0;
  logic             reset_i;
  logic [N-1:0]     src_v_i;
  logic [N*W-1:0]   src_data_i;
  logic [N-1:0]     src_last_i;
  logic [N-1:0]     src_yumi_o;
  logic             stream_v_o;
  logic [W-1:0]     stream_data_o;
  logic             stream_last_o;
  logic             stream_ready_i;
  logic [ID_W-1:0]  grant_id_o;
  logic             busy_o;
  logic             err_o;

  always #5 clk = ~clk;

  bp_stream_out_arbiter #(
    .num_src_p          (N),
    .stream_data_width_p(W),
    .max_beats_p        (MB)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .src_v_i       (src_v_i),
    .src_data_i    (src_data_i),
    .src_last_i    (src_last_i),
    .src_yumi_o    (src_yumi_o),
    .stream_v_o    (stream_v_o),
    .stream_data_o (stream_data_o),
    .stream_last_o (stream_last_o),
    .stream_ready_i(stream_ready_i),
    .grant_id_o    (grant_id_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
    logic            busy;
    logic [W-1:0]    data;
  } exp_t;

  exp_t       exp_q[$];
  logic [W:0] q0[$], q1[$], q2[$];  // {last, data}
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic add_beat(input int s, input logic last, input logic [W-1:0] d);
    case (s)
      0:       q0.push_back({last, d});
      1:       q1.push_back({last, d});
      default: q2.push_back({last, d});
    endcase
  endtask

  task automatic expect_beat(input int id, input logic last, input logic busy,
                             input logic [W-1:0] d);
    exp_t e;
    e.id   = ID_W'(id);
    e.last = last;
    e.busy = busy;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_srcs();
    logic [W:0] h;
    logic       v;
    for (int s = 0; s < N; s++) begin
      v = 1'b0;
      h = '0;
      case (s)
        0:       if (q0.size() > 0) begin v = 1'b1; h = q0[0]; end
        1:       if (q1.size() > 0) begin v = 1'b1; h = q1[0]; end
        default: if (q2.size() > 0) begin v = 1'b1; h = q2[0]; end
      endcase
      src_v_i[s]          = v;
      src_last_i[s]       = v & h[W];
      src_data_i[s*W +: W] = h[W-1:0];
    end
  endtask

  // One clock: sample just after the falling edge, advance sources on yumi,
  // score any host handshake, then drive the next source heads.
  task automatic tick();
    logic [N-1:0]    y;
    logic            hs;
    logic [W-1:0]    d;
    logic            l;
    logic            b;
    logic [ID_W-1:0] g;
    exp_t            e;
    #1;
    y  = src_yumi_o;
    hs = stream_v_o & stream_ready_i;
    d  = stream_data_o;
    l  = stream_last_o;
    b  = busy_o;
    g  = grant_id_o;
    checks++;
    if ($countones(y) > 1) begin
      errors++;
      $display("FAIL yumi_onehot: got %b, required at most one bit set", y);
    end
    @(posedge clk);
    if (y[0] && q0.size() > 0) void'(q0.pop_front());
    if (y[1] && q1.size() > 0) void'(q1.pop_front());
    if (y[2] && q2.size() > 0) void'(q2.pop_front());
    if (hs === 1'b1) begin
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h last=%b id=%0d, required no beat", d, l, g);
      end else begin
        e = exp_q.pop_front();
        if ({g, l, b, d} !== {e.id, e.last, e.busy, e.data}) begin
          errors++;
          $display("FAIL beat: got id=%0d last=%b busy=%b data=%h, required id=%0d last=%b busy=%b data=%h",
                   g, l, b, d, e.id, e.last, e.busy, e.data);
        end
      end
    end
    @(negedge clk);
    drive_srcs();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats still pending after %0d cycles, required 0",
               exp_q.size(), limit);
    end
  endtask

  task automatic do_reset();
    exp_q.delete();
    q0.delete(); q1.delete(); q2.delete();
    reset_i = 1'b0;
    stream_ready_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i        = 1'b0;
    stream_ready_i = 1'b1;
    src_v_i        = '1;
    src_last_i     = '1;
    src_data_i     = '1;
    #1;
    checks++;
    if (src_yumi_o !== 3'b000) begin
      errors++;
      $display("FAIL reset_yumi: got %b, required 000", src_yumi_o);
    end
    tick();
    tick();
    #1;
    checks++;
    if ({stream_v_o, stream_data_o, stream_last_o, busy_o, err_o, grant_id_o} !==
        {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL reset_state: got v=%b data=%h last=%b busy=%b err=%b gid=%0d, required 0 0 0 0 0 2",
               stream_v_o, stream_data_o, stream_last_o, busy_o, err_o, grant_id_o);
    end
    reset_i = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    add_beat(0, 1'b1, 32'hA5);
    expect_beat(0, 1'b1, 1'b0, 32'hA5);
    drive_srcs();
    #1;
    checks++;
    if (src_yumi_o !== 3'b001 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got yumi=%b busy=%b, required 001 0", src_yumi_o, busy_o);
    end
    tick();
    #1;
    checks++;
    if (stream_v_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got v=%b busy=%b, required 1 0", stream_v_o, busy_o);
    end
    drain(10);
  endtask

  task automatic test_round_robin();
    int hs0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_beat(0, 1'b1, 32'h10);
      add_beat(1, 1'b1, 32'h20);
      add_beat(2, 1'b1, 32'h30);
      expect_beat(0, 1'b1, 1'b0, 32'h10);
      expect_beat(1, 1'b1, 1'b0, 32'h20);
      expect_beat(2, 1'b1, 1'b0, 32'h30);
    end
    hs0 = hs_cnt;
    drive_srcs();
    repeat (7) tick();
    checks++;
    if (hs_cnt - hs0 != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_no_bubble: got %0d beats in 7 cycles (%0d pending), required 6 (0)",
               hs_cnt - hs0, exp_q.size());
    end
    drain(10);
  endtask

  task automatic test_packet_lock();
    do_reset();
    add_beat(0, 1'b1, 32'h0F);
    expect_beat(0, 1'b1, 1'b0, 32'h0F);
    drive_srcs();
    drain(10);
    for (int b = 1; b <= 4; b++) begin
      add_beat(1, b == 4, W'(b));
      expect_beat(1, b == 4, b != 4, W'(b));
    end
    add_beat(0, 1'b1, 32'hA0);
    add_beat(2, 1'b1, 32'hC0);
    expect_beat(2, 1'b1, 1'b0, 32'hC0);
    expect_beat(0, 1'b1, 1'b0, 32'hA0);
    drive_srcs();
    drain(20);
  endtask

  task automatic test_back_to_back();
    stream_ready_i = 1'b0;
    add_beat(1, 1'b1, 32'h55);
    add_beat(1, 1'b1, 32'h66);
    expect_beat(1, 1'b1, 1'b0, 32'h55);
    expect_beat(1, 1'b1, 1'b0, 32'h66);
    drive_srcs();
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (stream_v_o !== 1'b1 || stream_data_o !== 32'h55 || src_yumi_o !== 3'b000) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got v=%b data=%h yumi=%b, required 1 00000055 000",
                 c, stream_v_o, stream_data_o, src_yumi_o);
      end
      tick();
    end
    stream_ready_i = 1'b1;
    #1;
    checks++;
    if (src_yumi_o !== 3'b010) begin
      errors++;
      $display("FAIL backpressure_release: got yumi=%b, required 010", src_yumi_o);
    end
    drain(10);
  endtask

  task automatic test_overrun();
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_before_overrun: got %b, required 0", err_o);
    end
    for (int b = 1; b <= 6; b++) add_beat(0, 1'b0, 32'h100 + W'(b));
    add_beat(1, 1'b1, 32'hB1);
    expect_beat(0, 1'b0, 1'b1, 32'h101);
    expect_beat(0, 1'b0, 1'b1, 32'h102);
    expect_beat(0, 1'b0, 1'b1, 32'h103);
    expect_beat(0, 1'b1, 1'b0, 32'h104);
    expect_beat(1, 1'b1, 1'b0, 32'hB1);
    expect_beat(0, 1'b0, 1'b1, 32'h105);
    expect_beat(0, 1'b0, 1'b1, 32'h106);
    drive_srcs();
    drain(30);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, required 1", err_o);
    end
    add_beat(0, 1'b1, 32'hE0);
    expect_beat(0, 1'b1, 1'b0, 32'hE0);
    drive_srcs();
    drain(10);
    repeat (3) tick();
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b busy=%b, required 1 0", err_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int b = 1; b <= 4; b++) add_beat(1, b == 4, 32'h60 + W'(b));
    add_beat(0, 1'b1, 32'hD0);
    expect_beat(1, 1'b0, 1'b1, 32'h61);
    drive_srcs();
    tick();
    tick();
    stream_ready_i = 1'b0;
    reset_i        = 1'b0;
    #1;
    checks++;
    if (src_yumi_o !== 3'b000 || stream_data_o !== 32'h62) begin
      errors++;
      $display("FAIL mid_reset_inflight: got yumi=%b data=%h, required 000 00000062",
               src_yumi_o, stream_data_o);
    end
    tick();
    #1;
    checks++;
    if ({stream_v_o, busy_o, err_o, grant_id_o} !== {1'b0, 1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL mid_reset_state: got v=%b busy=%b err=%b gid=%0d, required 0 0 0 2",
               stream_v_o, busy_o, err_o, grant_id_o);
    end
    reset_i        = 1'b1;
    stream_ready_i = 1'b1;
    exp_q.delete();
    q1.delete();
    for (int b = 1; b <= 4; b++) add_beat(1, b == 4, 32'h60 + W'(b));
    expect_beat(0, 1'b1, 1'b0, 32'hD0);
    for (int b = 1; b <= 4; b++) expect_beat(1, b == 4, b != 4, 32'h60 + W'(b));
    drive_srcs();
    drain(20);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_round_robin();
    test_packet_lock();
    test_back_to_back();
    test_overrun();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
